// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the processor core
// and the loader/debug port. One access runs at a time: IDLE -> ACCESS
// (WAIT_CYCLES cycles) -> DONE (one-cycle ready pulse) -> IDLE.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise the core
// always wins when both ports request in the same IDLE cycle.
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ready,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt_q, gnt_d;
  logic          pick_l;
  logic          start;

  // A new access starts whenever either port requests while idle.
  assign start = (state_q == IDLE) && (c_req || l_req);

`ifdef MEM_ARBITER_RR_EN
  // rr_q remembers the last granted port (1 = loader); reset favours the core.
  logic rr_q, rr_d;

  // Tie goes to whichever port was not granted last.
  always_comb begin
    pick_l = l_req && (!c_req || !rr_q);
  end

  // Pointer follows every grant.
  always_comb begin
    rr_d = rr_q;
    if (start) rr_d = pick_l;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b1;
    else        rr_q <= rr_d;
  end
`else
  // Fixed priority: the loader only wins when the core is not requesting.
  always_comb begin
    pick_l = l_req && !c_req;
  end
`endif

  // Next-state logic: latch the winner in IDLE, count down in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d   = pick_l;
          we_d    = pick_l ? l_we    : c_we;
          addr_d  = pick_l ? l_addr  : c_addr;
          wdata_d = pick_l ? l_wdata : c_wdata;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = m_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs decode from registered state so reset clears them asynchronously.
  always_comb begin
    m_en    = (state_q == ACCESS);
    m_we    = (state_q == ACCESS) && we_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    c_ready = (state_q == DONE) && !gnt_q;
    l_ready = (state_q == DONE) && gnt_q;
    c_rdata = rdata_q;
    l_rdata = rdata_q;
    busy    = (state_q != IDLE);
    gnt     = gnt_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiter instances (WAIT_CYCLES=1 and 3) with a simple
// memory model each. Stimulus pushes expected ready events (port, data,
// cycle) into a scoreboard; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  typedef struct {
    int          inst;
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sbq[$];

  logic        c_req   [2];
  logic        c_we    [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic        c_ready [2];
  logic [31:0] c_rdata [2];
  logic        l_req   [2];
  logic        l_we    [2];
  logic [31:0] l_addr  [2];
  logic [31:0] l_wdata [2];
  logic        l_ready [2];
  logic [31:0] l_rdata [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        busy    [2];
  logic        gnt     [2];
  logic [31:0] mem     [2][64];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .AW(32),
      .DW(32),
      .WAIT_CYCLES(g == 0 ? 1 : 3)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .c_req(c_req[g]),
      .c_we(c_we[g]),
      .c_addr(c_addr[g]),
      .c_wdata(c_wdata[g]),
      .c_ready(c_ready[g]),
      .c_rdata(c_rdata[g]),
      .l_req(l_req[g]),
      .l_we(l_we[g]),
      .l_addr(l_addr[g]),
      .l_wdata(l_wdata[g]),
      .l_ready(l_ready[g]),
      .l_rdata(l_rdata[g]),
      .m_en(m_en[g]),
      .m_we(m_we[g]),
      .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]),
      .busy(busy[g]),
      .gnt(gnt[g])
    );
  end

  // Word-addressed memory models, combinational read.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++)
      if (m_en[g] && m_we[g]) mem[g][m_addr[g][7:2]] <= m_wdata[g];
  end

  always_comb begin
    for (int g = 0; g < 2; g++) m_rdata[g] = mem[g][m_addr[g][7:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (c_ready[g] || l_ready[g]) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: inst %0d c_ready=%0b l_ready=%0b got a pulse expected none",
                   g, c_ready[g], l_ready[g]);
        end else begin
          e = sbq.pop_front();
          chk("ready_inst", 64'(g), 64'(e.inst));
          chk("ready_port", {62'd0, c_ready[g], l_ready[g]}, e.port ? 64'd1 : 64'd2);
          chk("gnt", {63'd0, gnt[g]}, {63'd0, e.port});
          chk("rdata", {32'd0, e.port ? l_rdata[g] : c_rdata[g]}, {32'd0, e.data});
          chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic drive(input int i, input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      l_req[i] = req; l_we[i] = we; l_addr[i] = addr; l_wdata[i] = wdata;
    end else begin
      c_req[i] = req; c_we[i] = we; c_addr[i] = addr; c_wdata[i] = wdata;
    end
  endtask

  task automatic push(input int i, input bit port, input logic [31:0] data, input int at);
    exp_t e;
    e.inst = i; e.port = port; e.data = data; e.cyc = at;
    sbq.push_back(e);
  endtask

  task automatic wait_ready(input int i, input bit port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? l_ready[i] : c_ready[i]) && n < 60);
    if (!(port ? l_ready[i] : c_ready[i])) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: inst %0d port %0d got no ready expected one within 60 cycles", i, port);
    end
  endtask

  // One access issued from an idle arbiter; ready expected at request cycle + W + 1.
  task automatic single(input int i, input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] data, input int w);
    @(negedge clk);
    drive(i, port, 1'b1, we, addr, wdata);
    push(i, port, data, cyc + w + 1);
    wait_ready(i, port);
    drive(i, port, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    int idle;
    int got;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(i, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs",
          {m_en[i], m_we[i], m_addr[i], busy[i], gnt[i], c_ready[i], l_ready[i], c_rdata[i][24:0]},
          64'd0);
    chk("reset_wdata_rdata", {m_wdata[0], l_rdata[1]}, 64'd0);
    reset = 1'b1;

    // W=1: loader preload, then core read 0x10 two cycles after request.
    single(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1);
    single(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);

    // W=1: back-to-back core reads of 0x0 and 0x4.
    single(0, 1'b1, 1'b1, 32'h0, 32'h11111111, 32'hDEADBEEF, 1);
    single(0, 1'b1, 1'b1, 32'h4, 32'h22222222, 32'hDEADBEEF, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h0, '0);
    push(0, 1'b0, 32'h11111111, cyc + 2);
    wait_ready(0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h4, '0);
    push(0, 1'b0, 32'h22222222, cyc + 3);
    idle = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy[0]) idle++;
      if (!c_ready[0]) chk("b2b_rdata_hold", {32'd0, c_rdata[0]}, 64'h11111111);
    end while (!c_ready[0] && n < 20);
    chk("b2b_idle_cycles", 64'(idle), 64'd1);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);

    // W=3: loader write 0x12345678 to 0x40, memory write strobe for 3 cycles.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    push(1, 1'b1, 32'h0, cyc + 4);
    cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_en[1] && m_we[1]) begin
        cnt++;
        chk("lw_m_addr_wdata", {m_addr[1], m_wdata[1]}, {32'h40, 32'h12345678});
      end
    end while (!l_ready[1] && n < 20);
    chk("lw_we_cycles", 64'(cnt), 64'd3);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);
    single(1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678, 3);

    // W=3: request fields change mid-access; latched values must be used.
    single(1, 1'b1, 1'b1, 32'h10, 32'hCAFE0010, 32'h12345678, 3);
    single(1, 1'b1, 1'b1, 32'h20, 32'hCAFE0020, 32'h12345678, 3);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h10, '0);
    push(1, 1'b0, 32'hCAFE0010, cyc + 4);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_en[1]) chk("latched_addr_we", {31'd0, m_we[1], m_addr[1]}, {31'd0, 1'b0, 32'h10});
    end while (!c_ready[1] && n < 20);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);

    // W=3: reset in the second ACCESS cycle aborts; held request restarts.
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h20, '0);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_abort_outputs", {59'd0, m_en[1], busy[1], gnt[1], c_ready[1], l_ready[1]}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push(1, 1'b0, 32'hCAFE0020, cyc + 4);
    wait_ready(1, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);

    // W=3: both ports hold requests from a fresh reset.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h10, '0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h20, '0);
`ifdef MEM_ARBITER_RR_EN
    push(1, 1'b0, 32'hCAFE0010, cyc + 4);
    push(1, 1'b1, 32'hCAFE0020, cyc + 9);
    push(1, 1'b0, 32'hCAFE0010, cyc + 14);
    push(1, 1'b1, 32'hCAFE0020, cyc + 19);
`else
    push(1, 1'b0, 32'hCAFE0010, cyc + 4);
    push(1, 1'b0, 32'hCAFE0010, cyc + 9);
    push(1, 1'b0, 32'hCAFE0010, cyc + 14);
    push(1, 1'b0, 32'hCAFE0010, cyc + 19);
`endif
    got = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (c_ready[1] || l_ready[1]) got++;
    end while (got < 4 && n < 40);
    chk("tie_grant_count", 64'(got), 64'd4);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b1, 1'b0, 1'b0, '0, '0);

    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
